// File: rtl/ws_feed_pkg.sv
// Shared constants and state encoding for the weight-stationary array feeder.
package ws_feed_pkg;

  localparam int unsigned SIZE_DEF      = 4;
  localparam int unsigned BIT_WIDTH_DEF = 8;
  localparam int unsigned LANE_W        = BIT_WIDTH_DEF;

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    SHIFT   = 3'd1,
    STREAM  = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/ws_skew_line.sv
// Per-lane delay line of DELAY registers with synchronous active-low clear.
module ws_skew_line
  import ws_feed_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = BIT_WIDTH_DEF,
  parameter int unsigned DELAY     = 1
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic [BIT_WIDTH-1:0] din,
  output logic [BIT_WIDTH-1:0] dout
);

  generate
    if (DELAY == 0) begin : g_pass
      logic unused_ctl;
      assign unused_ctl = clk & clr_n;
      assign dout       = din;
    end else begin : g_dly
      logic [BIT_WIDTH-1:0] pipe [DELAY];

      always_ff @(posedge clk) begin
        if (!clr_n) begin
          for (int i = 0; i < int'(DELAY); i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= din;
          for (int i = 1; i < int'(DELAY); i++) pipe[i] <= pipe[i-1];
        end
      end

      assign dout = pipe[DELAY-1];
    end
  endgenerate

endmodule

// File: rtl/ws_feed_ctrl4x4.sv
// Feeder for the 4x4 weight-stationary array: weight collect/shift, skewed
// activation stream, drain and done. Define WS_FEED_WT_REUSE_EN for weight reuse.
module ws_feed_ctrl4x4
  import ws_feed_pkg::*;
#(
  parameter int unsigned SIZE      = SIZE_DEF,
  parameter int unsigned BIT_WIDTH = BIT_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef WS_FEED_WT_REUSE_EN
  input  logic                      wt_reuse,
`endif
  input  logic                      wt_valid,
  output logic                      wt_ready,
  input  logic [SIZE*BIT_WIDTH-1:0] wt_row,
  input  logic                      act_valid,
  output logic                      act_ready,
  input  logic [SIZE*BIT_WIDTH-1:0] act_vec,
  input  logic                      act_last,
  output logic                      control,
  output logic [SIZE*BIT_WIDTH-1:0] wt_arr,
  output logic [SIZE*BIT_WIDTH-1:0] data_arr,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned VEC_W = SIZE * BIT_WIDTH;
  localparam int unsigned CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(SIZE - 2);

  localparam logic [2:0] S_COLLECT = 3'(COLLECT);
  localparam logic [2:0] S_SHIFT   = 3'(SHIFT);
  localparam logic [2:0] S_STREAM  = 3'(STREAM);
  localparam logic [2:0] S_DRAIN   = 3'(DRAIN);
  localparam logic [2:0] S_DONE    = 3'(DONE);

  logic [2:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [VEC_W-1:0] feed, feed_n;
  logic [VEC_W-1:0] wt_n;
  logic [VEC_W-1:0] wbuf [SIZE];
  logic             wt_acc, act_acc;

  assign wt_acc  = wt_valid & wt_ready;
  assign act_acc = act_valid & act_ready;

  // Weight tile buffer; the final beat goes straight to wt_arr instead.
  always_ff @(posedge clk) begin
    if (wt_acc) wbuf[cnt] <= wt_row;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wt_n    = '0;
    feed_n  = '0;
    case (state)
      S_COLLECT: begin
        if (wt_acc) begin
          if (cnt == CNT_LAST) begin
            state_n = S_SHIFT;
            cnt_n   = '0;
            wt_n    = wt_row;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      S_SHIFT: begin
        // Rows go out last-beat first so beat i settles in PE row i.
        if (cnt == CNT_LAST) begin
          state_n = S_STREAM;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
          wt_n  = wbuf[CNT_PEN - cnt];
        end
      end
      S_STREAM: begin
        if (act_acc) begin
          feed_n = act_vec;
          if (act_last) state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Input stage plus the deepest skew lane must empty before done.
        if (cnt == CNT_LAST) begin
          state_n = S_DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
`ifdef WS_FEED_WT_REUSE_EN
        state_n = wt_reuse ? S_STREAM : S_COLLECT;
`else
        state_n = S_COLLECT;
`endif
      end
      default: begin
        state_n = S_COLLECT;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_COLLECT;
      cnt       <= '0;
      feed      <= '0;
      wt_arr    <= '0;
      control   <= 1'b0;
      wt_ready  <= 1'b0;
      act_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      feed      <= feed_n;
      wt_arr    <= wt_n;
      control   <= (state_n == S_SHIFT);
      wt_ready  <= (state_n == S_COLLECT);
      act_ready <= (state_n == S_STREAM);
      busy      <= (state_n != S_COLLECT);
      done      <= (state_n == S_DONE);
    end
  end

  // Lane k sees k extra register stages after the shared input stage.
  for (genvar k = 0; k < SIZE; k++) begin : g_lane
    ws_skew_line #(
      .BIT_WIDTH (BIT_WIDTH),
      .DELAY     (k)
    ) u_skew (
      .clk   (clk),
      .clr_n (rst_n),
      .din   (feed[k*BIT_WIDTH +: BIT_WIDTH]),
      .dout  (data_arr[k*BIT_WIDTH +: BIT_WIDTH])
    );
  end

endmodule
